// File: rtl/apb_regfile_completer.sv
// APB completer terminating transfers in a NUM_REGS x DATA_W register bank.
// Byte strobes on writes, PSLVERR on misaligned or out-of-range addresses.
// Optional feature macro APB_WAIT_STATE_EN: when defined, wait_i inserts
// 0..15 wait cycles per transfer; when undefined every transfer completes
// in its first access cycle and wait_i is ignored.
module apb_regfile_completer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  input  logic [3:0]            wait_i,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {IDLE, ACCESS} state_t;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (32'(a[ADDR_W-1:2]) < 32'(NUM_REGS));
  endfunction

  function automatic logic [31:0] addr_idx(input logic [ADDR_W-1:0] a);
    return 32'(a[ADDR_W-1:2]);
  endfunction

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                cap_write;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [NB-1:0]       cap_strb;

  logic                done, cap_en, wr_en;
  logic                pready_nxt, pslverr_nxt;
  logic [DATA_W-1:0]   prdata_nxt, rd_word;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_write, sel_legal;
  logic [31:0]         sel_idx, cap_idx;

`ifdef APB_WAIT_STATE_EN
  logic [3:0]          wcnt, wcnt_nxt;
`else
  logic                unused_wait;
  assign unused_wait = ^wait_i;
`endif

  // In IDLE the response is built from the live setup signals, in ACCESS from the captured ones
  assign sel_addr  = (state == IDLE) ? paddr  : cap_addr;
  assign sel_write = (state == IDLE) ? pwrite : cap_write;
  assign sel_legal = addr_legal(sel_addr);
  assign sel_idx   = addr_idx(sel_addr);
  assign cap_idx   = addr_idx(cap_addr);

  // Read mux over the bank, only meaningful for legal indices
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_idx == 32'(i)) rd_word = regs[i];
    end
  end

  // FSM state register
  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: completion or a dropped psel both close the transfer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (psel && !penable) state_nxt = ACCESS;
      ACCESS: if (!psel || pready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: decide when the response is ready and what it carries
  always_comb begin
    done   = 1'b0;
    cap_en = 1'b0;
    wr_en  = 1'b0;
`ifdef APB_WAIT_STATE_EN
    wcnt_nxt = wcnt;
`endif
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          cap_en = 1'b1;
`ifdef APB_WAIT_STATE_EN
          wcnt_nxt = wait_i;
          done     = (wait_i == 4'd0);
`else
          done     = 1'b1;
`endif
        end
      end
      ACCESS: begin
        if (psel) begin
          if (pready) begin
            wr_en = cap_write && addr_legal(cap_addr);
          end
`ifdef APB_WAIT_STATE_EN
          // Count 1 -> 0 is the last wait cycle, so pready rises right after it
          else if (wcnt <= 4'd1) begin
            done     = 1'b1;
            wcnt_nxt = 4'd0;
          end else begin
            wcnt_nxt = wcnt - 4'd1;
          end
`endif
        end
      end
      default: done = 1'b0;
    endcase
    pready_nxt  = done;
    pslverr_nxt = done && !sel_legal;
    prdata_nxt  = (done && sel_legal && !sel_write) ? rd_word : '0;
  end

  // Registered response outputs and wait counter
  always_ff @(posedge pclk) begin
    if (preset) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
`ifdef APB_WAIT_STATE_EN
      wcnt    <= 4'd0;
`endif
    end else begin
      pready  <= pready_nxt;
      pslverr <= pslverr_nxt;
      prdata  <= prdata_nxt;
`ifdef APB_WAIT_STATE_EN
      wcnt    <= wcnt_nxt;
`endif
    end
  end

  // Setup-phase capture; later changes on the bus are ignored
  always_ff @(posedge pclk) begin
    if (cap_en) begin
      cap_write <= pwrite;
      cap_addr  <= paddr;
      cap_wdata <= pwdata;
      cap_strb  <= pstrb;
    end
  end

  // Register bank: byte-strobed commit at the completion edge
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cap_idx == 32'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (cap_strb[b]) regs[i][8*b +: 8] <= cap_wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Self-checking bench for apb_regfile_completer (NUM_REGS=4, ADDR_W=8).
// Expected responses come from a byte-level register model and are queued at
// setup time, then popped and compared when pready is observed.
module tb_apb_regfile_completer;

  logic        pclk;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  wait_i;
  logic [31:0] prdata;
  logic        pready, pslverr;

  apb_regfile_completer #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(4)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .wait_i(wait_i), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [4];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_waits(input logic [3:0] w);
`ifdef APB_WAIT_STATE_EN
    return int'(w);
`else
    return (w == 4'd0) ? 0 : 0;
`endif
  endfunction

  // Caller is positioned just after a rising edge.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [3:0] w, input bit b2b);
    exp_t       e;
    logic       legal;
    logic [1:0] mi;
    int         wcount;
    bit         got;
    legal   = (addr[1:0] == 2'b00) && (addr[7:4] == 4'h0);
    mi      = addr[3:2];
    e.wr    = wr;
    e.err   = !legal;
    e.waits = exp_waits(w);
    e.data  = (wr || !legal) ? 32'h0 : model[mi];
    if (wr && legal)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[mi][8*b +: 8] = data[8*b +: 8];
    sb.push_back(e);

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; wait_i = w;
    @(posedge pclk); #1;
    penable = 1'b1;
    // Scramble bus fields during ACCESS; the DUT must use the captured copies
    paddr = ~addr; pwdata = ~data; pstrb = ~strb;
    wcount = 0;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      if (pready) begin
        got = 1'b1;
        break;
      end
      wcount++;
      @(posedge pclk); #1;
    end
    e = sb.pop_front();
    if (!got) begin
      chk("timeout", 32'd0, 32'd1);
    end else begin
      chk("waits", 32'(wcount), 32'(e.waits));
      chk("pslverr", 32'(pslverr), 32'(e.err));
      if (!e.wr) chk("prdata", prdata, e.data);
    end
    @(posedge pclk); #1;
    if (!b2b) begin
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      chk("idle_rdy", 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) xfer(1'b0, 8'(4 * i), 32'h0, 4'h0, 4'd1, 1'b0);
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; wait_i = '0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    @(posedge pclk); #1;

    // penable without a setup phase is ignored
    psel = 1'b1; penable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      chk("noset_rdy", 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;

    read_all();
    // Basic write/read, then a read with waits
    xfer(1'b1, 8'h04, 32'h1234ABCD, 4'hF, 4'd0, 1'b0);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 4'd0, 1'b0);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 4'd3, 1'b0);
    // Partial write
    xfer(1'b1, 8'h04, 32'hFFFFFFFF, 4'b0011, 4'd0, 1'b0);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 4'd0, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 4'd0, 1'b0);
    // Error responses
    xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 4'd2, 1'b0);
    xfer(1'b0, 8'h02, 32'h0, 4'h0, 4'd0, 1'b0);
    xfer(1'b1, 8'h0E, 32'hCAFEF00D, 4'hF, 4'd0, 1'b0);
    read_all();

    // psel dropped during ACCESS: transfer aborted, nothing written
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
    pwdata = 32'h55AA55AA; pstrb = 4'hF; wait_i = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("abort_rdy", 32'(pready), (exp_waits(4'd5) == 0) ? 32'd1 : 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("abort_idle", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 4'd0, 1'b0);

    // Reset during ACCESS
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C;
    pwdata = 32'h77777777; pstrb = 4'hF; wait_i = 4'd2;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("rst_acc_rdy", 32'(pready), 32'd0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    @(posedge pclk); #1;
    read_all();

    // Back-to-back write then read
    xfer(1'b1, 8'h08, 32'hA5A5A5A5, 4'hF, 4'd0, 1'b1);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, 4'd7, 1'b0);

    // Random traffic
    for (int i = 0; i < 16; i++) begin
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), $urandom(),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end
    xfer(1'b0, 8'h0C, 32'h0, 4'h0, 4'd0, 1'b0);
    read_all();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
